// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// Owners keep the port for bursts of up to MAX_BURST beats, then the grant rotates.
// The port is never written while the FIFO reports full.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DW-1:0]        req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_we,
    output logic [DW-1:0]             fifo_data_in,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [DW-1:0]   req_arr [NREQ];
    logic [IW-1:0]   arb_base;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   pick;
    logic            found;
    logic            beat;
    logic            burst_end;

    // Unpack the flat requester data bus into one word per requester.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_arr[i] = req_data[i*DW +: DW];
        end
    end

    // Round-robin search: first valid requester after arb_base, arb_base itself last.
    always_comb begin
        arb_base = (state_q == GRANT) ? owner_q : rr_q;
        cand     = '0;
        pick     = '0;
        found    = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(arb_base) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // State, owner, burst counter and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and write-port outputs; outputs follow the registered state.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        beat         = 1'b0;
        burst_end    = 1'b0;
        fifo_we      = 1'b0;
        req_ready    = '0;
        fifo_data_in = '0;
        grant_id     = '0;
        busy         = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end

            GRANT: begin
                busy               = 1'b1;
                grant_id           = owner_q;
                fifo_data_in       = req_arr[owner_q];
                beat               = req_valid[owner_q] & ~fifo_full;
                fifo_we            = beat;
                req_ready[owner_q] = beat;

                if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end

                // A stalled owner with valid held keeps the grant indefinitely.
                burst_end = (beat && (cnt_q == CW'(MAX_BURST - 1))) || !req_valid[owner_q];

                if (burst_end) begin
                    rr_d  = owner_q;
                    cnt_d = '0;
                    if (found) begin
                        owner_d = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: producer models feed the arbiter, a scoreboard
// holds the expected {grant_id, data} write order and is drained as the FIFO port writes.
module tb_fifo_wr_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full;
    logic              fifo_we;
    logic [DW-1:0]     fifo_data_in;
    logic [1:0]        grant_id;
    logic              busy;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_we      (fifo_we),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          n_writes;
    logic [7:0]  pbuf [4][32];
    int          phead [4];
    int          ptail [4];
    logic [3:0]  en;
    logic        force_full;
    logic        use_model;
    int          fcnt;
    logic [15:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = en[i] && (phead[i] < ptail[i]);
            req_data[i*8 +: 8] = pbuf[i][phead[i]];
        end
        fifo_full = use_model ? (fcnt >= 16) : force_full;
    endtask

    task automatic load(input int id, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            pbuf[id][ptail[id]] = 8'(base + k);
            ptail[id]++;
        end
    endtask

    task automatic push(input int id, input int data);
        sb.push_back(16'(id * 256 + data));
    endtask

    // Observe one cycle of the write port and account accepted beats.
    task automatic sample();
        logic [15:0] exp;
        if (fifo_we) begin
            chk("we_while_full", 32'(fifo_full), 32'(0));
            chk("ready_onehot", 32'(req_ready), 32'(1) << grant_id);
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(sb.size()), 32'(1));
            end else begin
                exp = sb.pop_front();
                chk("write_data", 32'({grant_id, fifo_data_in}), 32'(exp));
            end
            n_writes++;
            if (use_model) fcnt++;
        end else begin
            chk("ready_no_write", 32'(req_ready), 32'(0));
        end
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) phead[i]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < 4; i++) begin
            if (phead[i] < ptail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain();
        for (int c = 0; c < 200; c++) begin
            if (!busy && all_empty()) break;
            step();
        end
        chk("drain_busy", 32'(busy), 32'(0));
        chk("sb_left", 32'(sb.size()), 32'(0));
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 4; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        en         = '0;
        force_full = 1'b0;
        use_model  = 1'b0;
        fcnt       = 0;
        n_writes   = 0;
        sb.delete();
        drive();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        clear_stim();
        #1;
        chk("rst_we", 32'(fifo_we), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_grant", 32'(grant_id), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_data", 32'(fifo_data_in), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int cnt;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 32; k++) pbuf[i][k] = 8'h00;
        clear_stim();

        // Single producer burst ended by a valid drop.
        reset_dut();
        pbuf[0][0] = 8'h11; pbuf[0][1] = 8'h22; pbuf[0][2] = 8'h33; ptail[0] = 3;
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        en = 4'b0001;
        step();
        chk("t1_idle_busy", 32'(busy), 32'(0));
        chk("t1_idle_we", 32'(fifo_we), 32'(0));
        for (int b = 0; b < 3; b++) begin
            step();
            chk("t1_beat_we", 32'(fifo_we), 32'(1));
            chk("t1_grant", 32'(grant_id), 32'(0));
        end
        step();
        chk("t1_drop_busy", 32'(busy), 32'(1));
        chk("t1_drop_we", 32'(fifo_we), 32'(0));
        step();
        chk("t1_busy_off", 32'(busy), 32'(0));
        chk("t1_sb_left", 32'(sb.size()), 32'(0));

        // All four requesters continuously valid: 4-beat bursts, round-robin, no bubble.
        reset_dut();
        for (int i = 0; i < 4; i++) load(i, 8, i * 16);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) push(i, i * 16 + r * 4 + k);
        en = 4'b1111;
        step();
        chk("t2_idle_we", 32'(fifo_we), 32'(0));
        cnt = 0;
        for (int c = 0; c < 32; c++) begin
            step();
            if (fifo_we) cnt++;
        end
        chk("t2_no_bubble", 32'(cnt), 32'(32));
        drain();

        // FIFO full stall after beat 2 of req1; burst still totals 4 beats.
        reset_dut();
        load(1, 6, 8'h10);
        load(2, 1, 8'h20);
        for (int k = 0; k < 4; k++) push(1, 8'h10 + k);
        push(2, 8'h20);
        push(1, 8'h14); push(1, 8'h15);
        en = 4'b0110;
        step();
        step();
        step();
        chk("t3_two_beats", 32'(n_writes), 32'(2));
        force_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t3_stall_we", 32'(fifo_we), 32'(0));
            chk("t3_stall_ready", 32'(req_ready), 32'(0));
            chk("t3_stall_grant", 32'(grant_id), 32'(1));
        end
        force_full = 1'b0;
        step();
        step();
        chk("t3_burst_total", 32'(n_writes), 32'(4));
        drain();

        // req0 drops after two beats; req2 is next, req1/req3 skipped.
        reset_dut();
        load(0, 2, 8'hA0);
        load(2, 2, 8'hC0);
        push(0, 8'hA0); push(0, 8'hA1); push(2, 8'hC0); push(2, 8'hC1);
        en = 4'b0101;
        step();
        step();
        step();
        step();
        chk("t4_drop_grant", 32'(grant_id), 32'(0));
        chk("t4_drop_we", 32'(fifo_we), 32'(0));
        step();
        chk("t4_next_grant", 32'(grant_id), 32'(2));
        chk("t4_next_busy", 32'(busy), 32'(1));
        drain();

        // Reset asserted mid-burst of req2, then arbitration restarts at req0.
        reset_dut();
        load(2, 4, 8'h40);
        for (int k = 0; k < 4; k++) push(2, 8'h40 + k);
        en = 4'b0100;
        step();
        step();
        step();
        @(posedge clk);
        #1;
        drive();
        chk("t5_inflight_we", 32'(fifo_we), 32'(1));
        rst = 1'b0;
        #1;
        chk("t5_rst_we", 32'(fifo_we), 32'(0));
        chk("t5_rst_busy", 32'(busy), 32'(0));
        chk("t5_rst_grant", 32'(grant_id), 32'(0));
        chk("t5_rst_ready", 32'(req_ready), 32'(0));
        clear_stim();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load(i, 1, 8'h50 + i);
            push(i, 8'h50 + i);
        end
        en = 4'b1111;
        step();
        chk("t5_idle_busy", 32'(busy), 32'(0));
        step();
        chk("t5_first_grant", 32'(grant_id), 32'(0));
        drain();

        // 16-deep FIFO model: 17 beats from req3, the 17th waits for a read.
        reset_dut();
        use_model = 1'b1;
        load(3, 17, 8'h60);
        for (int k = 0; k < 17; k++) push(3, 8'h60 + k);
        en = 4'b1000;
        for (int c = 0; c < 40; c++) begin
            if (n_writes >= 16) break;
            step();
        end
        chk("t6_sixteen", 32'(n_writes), 32'(16));
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_full_we", 32'(fifo_we), 32'(0));
            chk("t6_full_ready", 32'(req_ready), 32'(0));
            chk("t6_full_busy", 32'(busy), 32'(1));
        end
        chk("t6_held", 32'(n_writes), 32'(16));
        fcnt--;
        step();
        chk("t6_after_read_we", 32'(fifo_we), 32'(1));
        drain();
        chk("t6_total", 32'(n_writes), 32'(17));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
